fnd_scan_ctrl: RTL and testbench



---
 rtl/fnd_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// 4-digit FND front end: converts a 14-bit binary value to BCD using sequential
// double-dabble, then scans the digits onto the shared decoder with active-low commons.
module fnd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  bcd,
  output logic [3:0]  fnd_com
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [1:0]       state;
  logic [13:0]      bin;
  logic [15:0]      acc;
  logic [15:0]      acc_adj;
  logic [15:0]      acc_next;
  logic [3:0]       iter;
  logic [3:0][3:0]  disp;
  logic [PW-1:0]    pre;
  logic [1:0]       idx;
  logic [13:0]      clamped;

  assign clamped = (value > 14'd9999) ? 14'd9999 : value;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    acc_adj = acc;
    for (int unsigned n = 0; n < 4; n++) begin
      if (acc[n*4 +: 4] >= 4'd5) acc_adj[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
    end
    acc_next = {acc_adj[14:0], bin[13]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      bin   <= '0;
      acc   <= '0;
      iter  <= '0;
      disp  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin   <= clamped;
            acc   <= '0;
            iter  <= '0;
            ovf   <= (value > 14'd9999);
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          acc  <= acc_next;
          bin  <= {bin[12:0], 1'b0};
          iter <= iter + 4'd1;
          if (iter == 4'd13) begin
            disp  <= acc_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    logic blank;
    bcd     = disp[idx];
    fnd_com = 4'b1111;
    fnd_com[idx] = 1'b0;
    case (idx)
      2'd1:    blank = (disp[1] == 4'd0) && (disp[2] == 4'd0) && (disp[3] == 4'd0);
      2'd2:    blank = (disp[2] == 4'd0) && (disp[3] == 4'd0);
      2'd3:    blank = (disp[3] == 4'd0);
      default: blank = 1'b0;
    endcase
    if ((BLANK_LZ != 0) && blank) fnd_com = 4'b1111;
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: directed and random conversions checked against a
// decimal-arithmetic model of the displayed number and scan position.
module tb_fnd_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value = '0;
  logic        busy, done, ovf;
  logic [3:0]  bcd, fnd_com;
  logic        busy_nb, done_nb, ovf_nb;
  logic [3:0]  bcd_nb, fnd_com_nb;

  int n_assert = 0;
  int n_fail   = 0;
  int edges    = 0;
  int shown    = 0;

  fnd_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1)) u_dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy), .done(done), .ovf(ovf), .bcd(bcd), .fnd_com(fnd_com)
  );

  fnd_scan_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(0)) u_dut_nb (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .busy(busy_nb), .done(done_nb), .ovf(ovf_nb), .bcd(bcd_nb), .fnd_com(fnd_com_nb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  // Scan position follows from edges since reset release: 4 cycles per digit.
  task automatic chk_disp(input string tag);
    int i;
    int p;
    logic [3:0] one;
    logic [3:0] com;
    i   = (edges / 4) % 4;
    p   = pow10(i);
    one = 4'b0001;
    com = ~(one << i);
    chk({tag, "_bcd"}, {28'd0, bcd}, (shown / p) % 10);
    chk({tag, "_com"}, {28'd0, fnd_com}, (i > 0 && shown < p) ? 32'hF : {28'd0, com});
    chk({tag, "_bcd_nb"}, {28'd0, bcd_nb}, (shown / p) % 10);
    chk({tag, "_com_nb"}, {28'd0, fnd_com_nb}, {28'd0, com});
  endtask

  task automatic convert(input int v, input int lock_v, input int lock_c);
    int cl;
    cl    = (v > 9999) ? 9999 : v;
    value = 14'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == lock_c) begin
        value = 14'(lock_v);
        load  = 1'b1;
      end else begin
        load  = 1'b0;
      end
      chk("busy_conv", {31'd0, busy}, 1);
      chk("done_conv", {31'd0, done}, (c == 15) ? 1 : 0);
      if (c == 1) chk("ovf_conv", {31'd0, ovf}, (v > 9999) ? 1 : 0);
      if (c == 15) shown = cl;
      chk_disp("disp_conv");
      tick();
    end
    load = 1'b0;
    chk("busy_after", {31'd0, busy}, 0);
    chk("done_after", {31'd0, done}, 0);
    chk("ovf_after", {31'd0, ovf}, (v > 9999) ? 1 : 0);
  endtask

  task automatic scan(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk_disp(tag);
      chk("done_idle", {31'd0, done}, 0);
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_com", {28'd0, fnd_com}, 32'hE);
    chk("rst_bcd", {28'd0, bcd}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    edges = 0;
    shown = 0;
    scan(6, "post_rst");

    convert(1234, 0, 0);
    scan(20, "scan_1234");

    convert(7, 0, 0);
    scan(16, "scan_7");

    convert(16383, 0, 0);
    scan(8, "scan_ovf");
    convert(42, 0, 0);
    scan(16, "scan_42");

    convert(5000, 6000, 5);
    scan(4, "scan_5000");
    convert(6000, 0, 0);
    scan(4, "scan_6000");

    value = 14'd9876;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    repeat (6) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_ovf", {31'd0, ovf}, 0);
    chk("midrst_bcd", {28'd0, bcd}, 0);
    chk("midrst_com", {28'd0, fnd_com}, 32'hE);
    shown = 0;
    @(posedge clk);
    #2 reset = 1'b0;
    edges = 0;
    for (int k = 0; k < 20; k++) begin
      chk("midrst_nobusy", {31'd0, busy}, 0);
      chk_disp("midrst_disp");
      chk("midrst_nodone", {31'd0, done}, 0);
      tick();
    end
    convert(9876, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int v;
      int gap;
      v   = int'($urandom_range(0, 16383));
      gap = int'($urandom_range(0, 4));
      scan(gap, "rnd_gap");
      convert(v, 0, 0);
      scan(8, "rnd_scan");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
